// File: rtl/ln_stage3_isqrt_pwl_cfg.sv
// LayerNorm stage 3: 6-stage 1/sqrt(var+EPS) with a runtime-writable PWL table.
// Optional o_sat flag output is enabled by defining LN_ISQRT_SAT_FLAG_EN.
module ln_stage3_isqrt_pwl_cfg #(
  parameter int unsigned MEAN_W    = 32,
  parameter int unsigned VAR_W     = 16,
  parameter int unsigned OUT_W     = 16,
  parameter int unsigned BANK_W    = 2,
  parameter int unsigned SEG_BITS  = 3,
  parameter int unsigned FRAC_BITS = 8,
  parameter int unsigned COEF_W    = 16,
  parameter int unsigned EPS       = 1,
  parameter int unsigned OUT_SHIFT = 6
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_en,
  input  logic                  i_valid,
  input  logic [BANK_W-1:0]     i_bank_id,
  input  logic [MEAN_W-1:0]     i_mean,
  input  logic [VAR_W-1:0]      i_variance,
  input  logic                  i_cfg_we,
  input  logic [SEG_BITS:0]     i_cfg_addr,
  input  logic [COEF_W-1:0]     i_cfg_slope,
  input  logic [COEF_W-1:0]     i_cfg_icpt,
  output logic                  o_valid,
  output logic [OUT_W-1:0]      o_inv_sqrt,
  output logic [MEAN_W-1:0]     o_mean,
`ifdef LN_ISQRT_SAT_FLAG_EN
  output logic                  o_sat,
`endif
  output logic [BANK_W-1:0]     o_bank_id
);

  localparam int unsigned IDX_W   = SEG_BITS + 1;
  localparam int unsigned TBL_D   = 1 << IDX_W;
  localparam int unsigned E_W     = $clog2(VAR_W);
  localparam int unsigned SF_W    = SEG_BITS + FRAC_BITS;
  localparam int unsigned LSB_POS = VAR_W - 1 - SF_W;
  localparam int unsigned PROD_W  = COEF_W + FRAC_BITS + 1;
  localparam int unsigned Y_W     = COEF_W + 2;
  localparam int unsigned R_W     = Y_W - 1;
  localparam int unsigned NSTG    = 6;

  logic signed [COEF_W-1:0] r_tbl_slope [TBL_D];
  logic        [COEF_W-1:0] r_tbl_icpt  [TBL_D];

  logic                r_vld  [NSTG];
  logic [MEAN_W-1:0]   r_mean [NSTG];
  logic [BANK_W-1:0]   r_bank [NSTG];

  logic [VAR_W-1:0]         r_s1_x;
  logic [E_W-1:0]           r_s2_e;
  logic [SEG_BITS-1:0]      r_s2_seg;
  logic [FRAC_BITS-1:0]     r_s2_frac;
  logic                     r_s2_force;
  logic signed [COEF_W-1:0] r_s3_slope;
  logic [COEF_W-1:0]        r_s3_icpt;
  logic [FRAC_BITS-1:0]     r_s3_frac;
  logic [E_W-2:0]           r_s3_eh;
  logic                     r_s3_force;
  logic signed [PROD_W-1:0] r_s4_prod;
  logic [COEF_W-1:0]        r_s4_icpt;
  logic [E_W-2:0]           r_s4_eh;
  logic                     r_s4_force;
  logic [R_W-1:0]           r_s5_y;
  logic [E_W-2:0]           r_s5_eh;
  logic                     r_s5_force;
  logic [OUT_W-1:0]         r_out;

  logic [VAR_W:0]           w_s1_sum;
  logic                     w_s1_sat;
  logic [VAR_W-1:0]         w_s1_x;
  logic [E_W-1:0]           w_s2_e;
  logic [E_W-1:0]           w_s2_sh;
  logic [SEG_BITS-1:0]      w_s2_seg;
  logic [FRAC_BITS-1:0]     w_s2_frac;
  logic                     w_s2_zero;
  logic [IDX_W-1:0]         w_s3_idx;
  logic signed [PROD_W-1:0] w_s4_prod;
  logic signed [PROD_W-1:0] w_s5_sh;
  logic signed [Y_W-1:0]    w_s5_y;
  logic [R_W-1:0]           w_s6_r;
  logic                     w_s6_sat;

  // S1: epsilon add with saturation
  assign w_s1_sum = (VAR_W+1)'(i_variance) + (VAR_W+1)'(EPS);
  assign w_s1_sat = w_s1_sum[VAR_W];
  assign w_s1_x   = w_s1_sat ? '1 : w_s1_sum[VAR_W-1:0];

  // S2: leading-one detect, normalise, split into segment and fraction
  always_comb begin
    w_s2_e = '0;
    for (int i = 0; i < VAR_W; i++) begin
      if (r_s1_x[i]) w_s2_e = E_W'(i);
    end
  end
  assign w_s2_sh   = E_W'(VAR_W - 1) - w_s2_e;
  assign {w_s2_seg, w_s2_frac} = SF_W'((r_s1_x << w_s2_sh) >> LSB_POS);
  assign w_s2_zero = (r_s1_x == '0);

  // S3..S6 datapath
  assign w_s3_idx  = {r_s2_e[0], r_s2_seg};
  assign w_s4_prod = PROD_W'(r_s3_slope) * PROD_W'($signed({1'b0, r_s3_frac}));
  assign w_s5_sh   = r_s4_prod >>> FRAC_BITS;
  assign w_s5_y    = $signed({2'b00, r_s4_icpt}) - Y_W'(w_s5_sh);
  assign w_s6_r    = (r_s5_y >> r_s5_eh) >> OUT_SHIFT;
  assign w_s6_sat  = (w_s6_r >> OUT_W) != '0;

  // Coefficient table: written regardless of enable or reset
  always_ff @(posedge i_clk) begin
    if (i_cfg_we) begin
      r_tbl_slope[i_cfg_addr] <= $signed(i_cfg_slope);
      r_tbl_icpt[i_cfg_addr]  <= i_cfg_icpt;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < NSTG; i++) begin
        r_vld[i]  <= 1'b0;
        r_mean[i] <= '0;
        r_bank[i] <= '0;
      end
      r_s1_x     <= '0;
      r_s2_e     <= '0;
      r_s2_seg   <= '0;
      r_s2_frac  <= '0;
      r_s2_force <= 1'b0;
      r_s3_slope <= '0;
      r_s3_icpt  <= '0;
      r_s3_frac  <= '0;
      r_s3_eh    <= '0;
      r_s3_force <= 1'b0;
      r_s4_prod  <= '0;
      r_s4_icpt  <= '0;
      r_s4_eh    <= '0;
      r_s4_force <= 1'b0;
      r_s5_y     <= '0;
      r_s5_eh    <= '0;
      r_s5_force <= 1'b0;
      r_out      <= '0;
    end else if (i_en) begin
      r_vld[0]  <= i_valid;
      r_mean[0] <= i_mean;
      r_bank[0] <= i_bank_id;
      for (int i = 1; i < NSTG; i++) begin
        r_vld[i]  <= r_vld[i-1];
        r_mean[i] <= r_mean[i-1];
        r_bank[i] <= r_bank[i-1];
      end
      r_s1_x     <= w_s1_x;
      r_s2_e     <= w_s2_e;
      r_s2_seg   <= w_s2_seg;
      r_s2_frac  <= w_s2_frac;
      r_s2_force <= w_s2_zero;
      r_s3_slope <= r_tbl_slope[w_s3_idx];
      r_s3_icpt  <= r_tbl_icpt[w_s3_idx];
      r_s3_frac  <= r_s2_frac;
      r_s3_eh    <= r_s2_e[E_W-1:1];
      r_s3_force <= r_s2_force;
      r_s4_prod  <= w_s4_prod;
      r_s4_icpt  <= r_s3_icpt;
      r_s4_eh    <= r_s3_eh;
      r_s4_force <= r_s3_force;
      r_s5_y     <= w_s5_y[Y_W-1] ? '0 : w_s5_y[R_W-1:0];
      r_s5_eh    <= r_s4_eh;
      r_s5_force <= r_s4_force;
      r_out      <= (r_s5_force || w_s6_sat) ? '1 : OUT_W'(w_s6_r);
    end
  end

`ifdef LN_ISQRT_SAT_FLAG_EN
  logic r_sat [NSTG];

  // Saturation flag travels alongside the sample
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < NSTG; i++) r_sat[i] <= 1'b0;
    end else if (i_en) begin
      r_sat[0] <= w_s1_sat;
      r_sat[1] <= r_sat[0] | w_s2_zero;
      for (int i = 2; i < NSTG - 1; i++) r_sat[i] <= r_sat[i-1];
      r_sat[NSTG-1] <= r_sat[NSTG-2] | w_s6_sat;
    end
  end
  assign o_sat = r_sat[NSTG-1];
`endif

  assign o_valid    = r_vld[NSTG-1];
  assign o_mean     = r_mean[NSTG-1];
  assign o_bank_id  = r_bank[NSTG-1];
  assign o_inv_sqrt = r_out;

endmodule

// File: tb/tb_ln_stage3_isqrt_pwl_cfg.sv
// Scoreboard bench for ln_stage3_isqrt_pwl_cfg: directed samples, queued expectations, negedge monitor.
module tb_ln_stage3_isqrt_pwl_cfg;

  logic        clk = 1'b0;
  logic        i_rst = 1'b1;
  logic        i_en = 1'b1;
  logic        i_valid = 1'b0;
  logic [1:0]  i_bank_id = '0;
  logic [31:0] i_mean = '0;
  logic [15:0] i_variance = '0;
  logic        i_cfg_we = 1'b0;
  logic [3:0]  i_cfg_addr = '0;
  logic [15:0] i_cfg_slope = '0;
  logic [15:0] i_cfg_icpt = '0;
  logic        o_valid;
  logic [15:0] o_inv_sqrt;
  logic [31:0] o_mean;
  logic [1:0]  o_bank_id;
`ifdef LN_ISQRT_SAT_FLAG_EN
  logic        o_sat;
`endif

  ln_stage3_isqrt_pwl_cfg dut (
    .i_clk(clk), .i_rst(i_rst), .i_en(i_en), .i_valid(i_valid),
    .i_bank_id(i_bank_id), .i_mean(i_mean), .i_variance(i_variance),
    .i_cfg_we(i_cfg_we), .i_cfg_addr(i_cfg_addr), .i_cfg_slope(i_cfg_slope),
    .i_cfg_icpt(i_cfg_icpt), .o_valid(o_valid), .o_inv_sqrt(o_inv_sqrt),
    .o_mean(o_mean),
`ifdef LN_ISQRT_SAT_FLAG_EN
    .o_sat(o_sat),
`endif
    .o_bank_id(o_bank_id)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] r;
    logic [31:0] m;
    logic [1:0]  b;
    logic        s;
    int          due;
  } exp_t;

  exp_t        q[$];
  exp_t        cur;
  int          total = 0;
  int          bad = 0;
  int          en_cnt = 0;
  logic        last_en = 1'b0;
  logic [15:0] held_r = '0;
  logic [31:0] held_m = '0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%h required=%h t=%0t", nm, act, req, $time);
    end
  endtask

  // Count enabled edges so output latency can be measured in enabled cycles
  always @(posedge clk) begin
    last_en <= i_en;
    if (i_en) en_cnt <= en_cnt + 1;
  end

  // Monitor: pop on each newly presented result, check hold while frozen
  always @(negedge clk) begin
    if (o_valid) begin
      if (last_en) begin
        if (q.size() == 0) begin
          chk("unexpected_valid", 64'(o_inv_sqrt), 64'hFFFF_FFFF_FFFF_FFFF);
        end else begin
          cur = q.pop_front();
          chk("inv_sqrt", 64'(o_inv_sqrt), 64'(cur.r));
          chk("mean", 64'(o_mean), 64'(cur.m));
          chk("bank", 64'(o_bank_id), 64'(cur.b));
          chk("latency", 64'(en_cnt), 64'(cur.due));
`ifdef LN_ISQRT_SAT_FLAG_EN
          chk("sat", 64'(o_sat), 64'(cur.s));
`endif
          held_r = o_inv_sqrt;
          held_m = o_mean;
        end
      end else begin
        chk("hold_inv", 64'(o_inv_sqrt), 64'(held_r));
        chk("hold_mean", 64'(o_mean), 64'(held_m));
      end
    end
  end

  task automatic issue(input logic [15:0] v, input logic [31:0] m, input logic [1:0] b,
                       input logic [15:0] r, input logic s);
    exp_t e;
    @(negedge clk);
    i_cfg_we   = 1'b0;
    i_valid    = 1'b1;
    i_variance = v;
    i_mean     = m;
    i_bank_id  = b;
    e.r = r; e.m = m; e.b = b; e.s = s; e.due = en_cnt + 6;
    q.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      i_valid    = 1'b0;
      i_cfg_we   = 1'b0;
      i_variance = 16'h1234;
    end
  endtask

  task automatic cfg(input logic [3:0] a, input logic [15:0] sl, input logic [15:0] ic);
    @(negedge clk);
    i_valid     = 1'b0;
    i_cfg_we    = 1'b1;
    i_cfg_addr  = a;
    i_cfg_slope = sl;
    i_cfg_icpt  = ic;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_valid", 64'(o_valid), 64'd0);
    chk("rst_inv", 64'(o_inv_sqrt), 64'd0);
    chk("rst_mean", 64'(o_mean), 64'd0);
    chk("rst_bank", 64'(o_bank_id), 64'd0);
    @(negedge clk);
    i_rst = 1'b0;

    cfg(4'd0,  16'h0000, 16'h8000);
    cfg(4'd8,  16'h0100, 16'h5A82);
    cfg(4'd1,  16'h7FFF, 16'h0010);
    cfg(4'd2,  16'hFF00, 16'h7FF8);
    cfg(4'd15, 16'h0000, 16'hFFFF);
    idle(1);

    // Single samples and a spread of exponents/segments
    issue(16'h0000, 32'h1111_0001, 2'd1, 16'h0200, 1'b0);
    idle(1);
    issue(16'h000F, 32'h8000_0002, 2'd2, 16'h0080, 1'b0);
    issue(16'h807F, 32'hFFFF_FFFD, 2'd3, 16'h0002, 1'b0);
    issue(16'h7FFF, 32'h0000_0004, 2'd0, 16'h0002, 1'b0);
    issue(16'h0003, 32'h0000_0005, 2'd1, 16'h0100, 1'b0);
    issue(16'h487F, 32'h0000_0006, 2'd2, 16'h0000, 1'b0);
    issue(16'h503F, 32'h0000_0007, 2'd3, 16'h0004, 1'b0);
    issue(16'hFFFF, 32'h0000_0008, 2'd0, 16'h0007, 1'b1);
    idle(10);

    // Back-to-back with a two-cycle freeze mid-flight
    issue(16'h0000, 32'hA000_0001, 2'd1, 16'h0200, 1'b0);
    issue(16'h000F, 32'hA000_0002, 2'd2, 16'h0080, 1'b0);
    issue(16'h0003, 32'hA000_0003, 2'd3, 16'h0100, 1'b0);
    idle(2);
    @(negedge clk); i_en = 1'b0;
    @(negedge clk);
    @(negedge clk); i_en = 1'b1;
    idle(10);

    // Reset with four samples in flight; nothing stale may emerge
    issue(16'h0000, 32'hB000_0001, 2'd1, 16'h0200, 1'b0);
    issue(16'h000F, 32'hB000_0002, 2'd2, 16'h0080, 1'b0);
    issue(16'h0003, 32'hB000_0003, 2'd3, 16'h0100, 1'b0);
    issue(16'h7FFF, 32'hB000_0004, 2'd0, 16'h0002, 1'b0);
    @(negedge clk);
    i_valid = 1'b0;
    i_rst   = 1'b1;
    q.delete();
    @(negedge clk);
    i_rst = 1'b0;
    chk("midrst_valid", 64'(o_valid), 64'd0);
    idle(8);
    issue(16'h0000, 32'hC000_0001, 2'd2, 16'h0200, 1'b0);
    idle(10);

    // Table write on the same edge sample A reads idx0; sample B reads after it
    issue(16'h0000, 32'hD000_0001, 2'd1, 16'h0200, 1'b0);
    issue(16'h0000, 32'hD000_0002, 2'd2, 16'h0100, 1'b0);
    cfg(4'd0, 16'h0000, 16'h4000);
    idle(1);
    issue(16'h000F, 32'hD000_0003, 2'd3, 16'h0040, 1'b0);
    idle(2);

    for (int i = 0; i < 50 && q.size() != 0; i++) @(negedge clk);
    chk("drain", 64'(q.size()), 64'd0);
    idle(3);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
